// File: rtl/nmea_rmc_parser.sv
// Extracts UTC time and fix status from $GxRMC sentences on a byte stream and presents local time.
// Define RMC_CHECKSUM_EN to require a matching *HH checksum before a frame is accepted.
module nmea_rmc_parser #(
   parameter int TZ_OFFSET_H = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_vld,
   output logic [23:0] time_bcd,
   output logic        fix_valid,
   output logic        time_vld,
   output logic        frame_err
);
   localparam logic [6:0] MAX_LEN = 7'd82;

   typedef enum logic [2:0] {
      IDLE, HDR, TIME, FIELD, STATUS, SKIP
`ifdef RMC_CHECKSUM_EN
      , CHK_HI, CHK_LO
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cks_q, cks_d;
   logic [6:0]  len_q, len_d;
   logic [2:0]  idx_q, idx_d;
   logic [19:0] dig_q, dig_d;
   logic [23:0] tcap_q, tcap_d;
   logic        fixp_q, fixp_d;
   logic [23:0] time_q, time_d;
   logic        fix_q, fix_d;
   logic        vld_q, err_q;
   logic        acc, rej;
`ifdef RMC_CHECKSUM_EN
   logic [3:0]  chk_hi_q, chk_hi_d;
   logic        hex_ok;
   logic [3:0]  hex_val;
`endif

   logic [23:0] nxt_dig;
   logic        is_dig, hdr_ok, time_ok;
   logic [4:0]  hh_bin, hh_loc;
   logic [5:0]  hh_sum;
   logic [3:0]  loc_t, loc_o;

   assign is_dig  = (rx_data >= "0") && (rx_data <= "9");
   assign nxt_dig = {dig_q, rx_data[3:0]};

   always_comb begin
      case (idx_q)
         3'd0:    hdr_ok = (rx_data == "G");
         3'd1:    hdr_ok = (rx_data == "N") || (rx_data == "P");
         3'd2:    hdr_ok = (rx_data == "R");
         3'd3:    hdr_ok = (rx_data == "M");
         3'd4:    hdr_ok = (rx_data == "C");
         3'd5:    hdr_ok = (rx_data == ",");
         default: hdr_ok = 1'b0;
      endcase
   end

   // Range check and local-hour conversion of the six digits, valid when the last digit arrives.
   always_comb begin
      time_ok = ((nxt_dig[23:20] < 4'd2) || ((nxt_dig[23:20] == 4'd2) && (nxt_dig[19:16] <= 4'd3)))
             && (nxt_dig[15:12] <= 4'd5)
             && ((nxt_dig[7:4] <= 4'd5) || ((nxt_dig[7:4] == 4'd6) && (nxt_dig[3:0] == 4'd0)));
      hh_bin  = 5'(nxt_dig[23:20]) * 5'd10 + 5'(nxt_dig[19:16]);
      hh_sum  = 6'(hh_bin) + 6'(TZ_OFFSET_H);
      hh_loc  = (hh_sum >= 6'd24) ? 5'(hh_sum - 6'd24) : hh_sum[4:0];
      if (hh_loc >= 5'd20) begin
         loc_t = 4'd2;
         loc_o = 4'(hh_loc - 5'd20);
      end else if (hh_loc >= 5'd10) begin
         loc_t = 4'd1;
         loc_o = 4'(hh_loc - 5'd10);
      end else begin
         loc_t = 4'd0;
         loc_o = hh_loc[3:0];
      end
   end

`ifdef RMC_CHECKSUM_EN
   always_comb begin
      hex_ok  = 1'b1;
      hex_val = 4'd0;
      if (is_dig)
         hex_val = rx_data[3:0];
      else if (((rx_data >= "A") && (rx_data <= "F")) || ((rx_data >= "a") && (rx_data <= "f")))
         hex_val = rx_data[3:0] + 4'd9;
      else
         hex_ok = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      cks_d   = cks_q;
      len_d   = len_q;
      idx_d   = idx_q;
      dig_d   = dig_q;
      tcap_d  = tcap_q;
      fixp_d  = fixp_q;
      acc     = 1'b0;
      rej     = 1'b0;
`ifdef RMC_CHECKSUM_EN
      chk_hi_d = chk_hi_q;
`endif
      if (rx_vld) begin
         if (rx_data == "$") begin
            rej     = (state_q != IDLE);
            state_d = HDR;
            cks_d   = 8'd0;
            len_d   = 7'd1;
            idx_d   = 3'd0;
         end else if (state_q != IDLE) begin
            len_d = len_q + 7'd1;
            if (len_q >= MAX_LEN) begin
               rej     = 1'b1;
               state_d = IDLE;
            end else begin
               // Only the terminating '*' in SKIP is left out of the running checksum.
               if ((state_q == HDR) || (state_q == TIME) || (state_q == FIELD) ||
                   (state_q == STATUS) || ((state_q == SKIP) && (rx_data != "*")))
                  cks_d = cks_q ^ rx_data;
               case (state_q)
                  HDR: begin
                     if (!hdr_ok) begin
                        state_d = IDLE;
                     end else if (idx_q == 3'd5) begin
                        state_d = TIME;
                        idx_d   = 3'd0;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  TIME: begin
                     if (!is_dig) begin
                        rej     = 1'b1;
                        state_d = IDLE;
                     end else if (idx_q == 3'd5) begin
                        if (time_ok) begin
                           tcap_d  = {loc_t, loc_o, nxt_dig[15:0]};
                           state_d = FIELD;
                        end else begin
                           rej     = 1'b1;
                           state_d = IDLE;
                        end
                     end else begin
                        dig_d = nxt_dig[19:0];
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  FIELD:  if (rx_data == ",") state_d = STATUS;
                  STATUS: begin
                     fixp_d  = (rx_data == "A");
                     state_d = SKIP;
                  end
                  SKIP: begin
                     if (rx_data == "*") begin
`ifdef RMC_CHECKSUM_EN
                        state_d = CHK_HI;
`else
                        acc     = 1'b1;
                        state_d = IDLE;
`endif
                     end
                  end
`ifdef RMC_CHECKSUM_EN
                  CHK_HI: begin
                     if (hex_ok) begin
                        chk_hi_d = hex_val;
                        state_d  = CHK_LO;
                     end else begin
                        rej     = 1'b1;
                        state_d = IDLE;
                     end
                  end
                  CHK_LO: begin
                     acc     = hex_ok && ({chk_hi_q, hex_val} == cks_q);
                     rej     = !acc;
                     state_d = IDLE;
                  end
`endif
                  default: state_d = IDLE;
               endcase
            end
         end
      end
      time_d = acc ? tcap_q : time_q;
      fix_d  = acc ? fixp_q : fix_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cks_q    <= 8'd0;
         len_q    <= 7'd0;
         idx_q    <= 3'd0;
         dig_q    <= 20'd0;
         tcap_q   <= 24'd0;
         fixp_q   <= 1'b0;
         time_q   <= 24'd0;
         fix_q    <= 1'b0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef RMC_CHECKSUM_EN
         chk_hi_q <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         cks_q    <= cks_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         dig_q    <= dig_d;
         tcap_q   <= tcap_d;
         fixp_q   <= fixp_d;
         time_q   <= time_d;
         fix_q    <= fix_d;
         vld_q    <= acc;
         err_q    <= rej;
`ifdef RMC_CHECKSUM_EN
         chk_hi_q <= chk_hi_d;
`endif
      end
   end

   assign time_bcd  = time_q;
   assign fix_valid = fix_q;
   assign time_vld  = vld_q;
   assign frame_err = err_q;
endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Scoreboard bench for nmea_rmc_parser: a sentence-level model predicts each frame's outcome,
// a monitor matches every time_vld / frame_err pulse against the predicted queue.
module tb_nmea_rmc_parser;
   localparam int TZ = 8;
   localparam int LIM = 82;
   localparam int K_NONE = 0, K_ACC = 1, K_REJ = 2, K_PEND = 3;
`ifdef RMC_CHECKSUM_EN
   localparam int CKL = 2;
`else
   localparam int CKL = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_vld = 1'b0;
   logic [23:0] time_bcd;
   logic        fix_valid, time_vld, frame_err;

   nmea_rmc_parser #(.TZ_OFFSET_H(TZ)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
      .time_bcd(time_bcd), .fix_valid(fix_valid), .time_vld(time_vld), .frame_err(frame_err)
   );

   always #10 clk = ~clk;

   typedef struct {
      int          kind;
      longint      cyc;
      logic [23:0] t;
      logic        fx;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          checks = 0;
   int          errors = 0;
   longint      cyc = 0;
   logic [23:0] last_t = 24'd0;
   logic        last_fx = 1'b0;
   bit          pending = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int hexv(input byte b);
      int v;
      v = int'(b);
      if (v >= 48 && v <= 57) return v - 48;
      if (v >= 65 && v <= 70) return v - 55;
      if (v >= 97 && v <= 102) return v - 87;
      return -1;
   endfunction

   // 0: index present, 1: stream ends first (frame still open), 2: over-length reject at LIM
   function automatic int reach(input int k, input int n);
      if (k >= LIM) return (n > LIM) ? 2 : 1;
      if (k >= n) return 1;
      return 0;
   endfunction

   // Sentence-level outcome of one '$'-started string: what happens and at which byte.
   function automatic void model(input string s, output int kind, output int idx,
                                 output logic [23:0] t, output logic fx);
      string hdr;
      int    n, hh, mm, ss, lh, c, st, star, r;
      logic [7:0] x;
      hdr  = "GNRMC,";
      n    = s.len();
      kind = K_PEND; idx = -1; t = last_t; fx = last_fx;
      for (int i = 1; i <= 6; i++) begin
         if (reach(i, n) != 0) return;
         if (!(s[i] == hdr[i-1] || (i == 2 && s[i] == "P"))) begin kind = K_NONE; return; end
      end
      for (int i = 7; i <= 12; i++) begin
         if (reach(i, n) != 0) return;
         if (s[i] < "0" || s[i] > "9") begin kind = K_REJ; idx = i; return; end
      end
      hh = (int'(s[7]) - 48) * 10 + int'(s[8]) - 48;
      mm = (int'(s[9]) - 48) * 10 + int'(s[10]) - 48;
      ss = (int'(s[11]) - 48) * 10 + int'(s[12]) - 48;
      if (hh > 23 || mm > 59 || ss > 60) begin kind = K_REJ; idx = 12; return; end
      lh = (hh + TZ) % 24;
      c = 13;
      forever begin
         r = reach(c, n);
         if (r == 1) return;
         if (r == 2) begin kind = K_REJ; idx = LIM; return; end
         if (s[c] == ",") break;
         c++;
      end
      st = c + 1;
      r = reach(st, n);
      if (r == 1) return;
      if (r == 2) begin kind = K_REJ; idx = LIM; return; end
      star = st + 1;
      forever begin
         r = reach(star, n);
         if (r == 1) return;
         if (r == 2) begin kind = K_REJ; idx = LIM; return; end
         if (s[star] == "*") break;
         star++;
      end
      x = 8'd0;
      for (int i = 1; i < star; i++) x = x ^ s[i];
      t  = {4'(lh / 10), 4'(lh % 10), 4'(int'(s[9]) - 48), 4'(int'(s[10]) - 48),
            4'(int'(s[11]) - 48), 4'(int'(s[12]) - 48)};
      fx = (s[st] == "A");
      idx = star;
`ifdef RMC_CHECKSUM_EN
      for (int k = 1; k <= 2; k++) begin
         r = reach(star + k, n);
         if (r == 1) begin t = last_t; fx = last_fx; idx = -1; return; end
         if (r == 2 || hexv(s[star + k]) < 0) begin
            kind = K_REJ; idx = (r == 2) ? LIM : star + k; t = last_t; fx = last_fx; return;
         end
      end
      idx = star + 2;
      if (hexv(s[star + 1]) * 16 + hexv(s[star + 2]) != int'(x)) begin
         kind = K_REJ; t = last_t; fx = last_fx; return;
      end
`endif
      kind = K_ACC;
   endfunction

   function automatic string mk(input string tk, input string tm, input string st,
                                input string tail, input int bad);
      string body, cs;
      logic [7:0] x;
      body = {tk, ",", tm, ",", st, ",", tail};
      x = 8'd0;
      for (int i = 0; i < body.len(); i++) x = x ^ body[i];
      x  = x + 8'(bad);
      cs = $sformatf("%02X", x);
      if ($urandom_range(0, 1) == 1) cs = cs.tolower();
      return {"$", body, "*", cs, "\r\n"};
   endfunction

   task automatic push(input int kind, input logic [23:0] t, input logic fx);
      exp_t e;
      e.kind = kind; e.cyc = cyc + 1; e.t = t; e.fx = fx;
      q.push_back(e);
   endtask

   task automatic send(input string s, input int gmin, input int gmax);
      int kind, idx;
      logic [23:0] t;
      logic fx;
      model(s, kind, idx, t, fx);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         if (i == 0 && pending) push(K_REJ, last_t, last_fx);
         if (i == idx) begin
            push(kind, t, fx);
            if (kind == K_ACC) begin last_t = t; last_fx = fx; end
         end
         rx_data = s[i];
         rx_vld  = 1'b1;
         repeat ($urandom_range(gmin, gmax)) begin
            @(negedge clk);
            rx_vld  = 1'b0;
            rx_data = 8'($urandom);
         end
      end
      @(negedge clk);
      rx_vld  = 1'b0;
      pending = (kind == K_PEND);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: actual none required kind %0d at cycle %0d", q[0].kind, q[0].cyc);
            void'(q.pop_front());
         end
         if (time_vld || frame_err) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: actual vld/err %b%b required none", time_vld, frame_err);
            end else begin
               me = q.pop_front();
               chk("pulse_cycle", 32'(cyc), 32'(me.cyc));
               chk("pulse_kind", {30'd0, time_vld, frame_err}, (me.kind == K_ACC) ? 32'd2 : 32'd1);
               chk("time_bcd", {8'd0, time_bcd}, {8'd0, me.t});
               chk("fix_valid", {31'd0, fix_valid}, {31'd0, me.fx});
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1);
   end

   initial begin
      string tail, pad, s, tm, st, tk;
      tail = "4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #4;
      chk("reset_time", {8'd0, time_bcd}, 32'd0);
      chk("reset_flags", {29'd0, fix_valid, time_vld, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      send(mk("GNRMC", "113232.00", "A", tail, 0), 0, 3);
      send(mk("GNRMC", "085903.000", "A", tail, 0), 0, 2);
      send(mk("GPRMC", "201500.00", "V", tail, 0), 0, 2);
      send(mk("GNRMC", "123456.00", "A", tail, 1), 0, 1);
      send("$GNRMC,1132", 0, 1);
      send(mk("GNRMC", "073000.00", "A", tail, 0), 0, 1);
      send(mk("GNGGA", "073001.00", "A", tail, 0), 0, 1);
      send(mk("GNRMC", "253000.00", "A", tail, 0), 0, 1);
      send(mk("GNRMC", "010203.00", "", tail, 0), 0, 1);
      send(mk("GNRMC", "235960.00", "A", tail, 0), 0, 1);
      send(mk("GNRMC", "235961.00", "A", tail, 0), 0, 1);
      send(mk("GNRMC", "236000.00", "A", tail, 0), 0, 1);
      send(mk("GNRMC", "12a456.00", "A", tail, 0), 0, 1);
      send("$GNRMC,1234,A,x*00\r\n", 0, 1);
      pad = "";
      repeat (80 - CKL - 18) pad = {pad, "x"};
      send(mk("GNRMC", "123456.00", "A", pad, 0), 0, 0);
      send(mk("GNRMC", "123457.00", "V", {pad, "x"}, 0), 0, 0);

      for (int k = 0; k < 40; k++) begin
         tm = $sformatf("%02d%02d%02d.%0d", $urandom_range(0, 27), $urandom_range(0, 61),
                        $urandom_range(0, 61), $urandom_range(0, 99));
         if ($urandom_range(0, 9) == 0) tm = {tm.substr(0, 1), "x", tm.substr(3, tm.len() - 1)};
         case ($urandom_range(0, 2))
            0:       st = "A";
            1:       st = "V";
            default: st = "";
         endcase
         tk = ($urandom_range(0, 9) == 0) ? "GNGGA" : (($urandom_range(0, 1) == 1) ? "GNRMC" : "GPRMC");
         s  = mk(tk, tm, st, tail, ($urandom_range(0, 4) == 0) ? 1 : 0);
         if ($urandom_range(0, 7) == 0) s = s.substr(0, $urandom_range(1, s.len() - 2));
         send(s, 0, 2);
      end

      send(mk("GNRMC", "101010.00", "A", tail, 0), 0, 1);
      send("$GNRMC,1132", 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("midframe_reset_time", {8'd0, time_bcd}, 32'd0);
      chk("midframe_reset_flags", {29'd0, fix_valid, time_vld, frame_err}, 32'd0);
      last_t  = 24'd0;
      last_fx = 1'b0;
      pending = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(mk("GPRMC", "155959.00", "A", tail, 0), 0, 0);
      send(mk("GNRMC", "000000.00", "V", tail, 0), 0, 0);

      repeat (20) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
